pipeline_hazard_ctrl: RTL and testbench
=======================================

// Module: pipeline_hazard_ctrl
// PURPOSE
//  Central stall/flush scheduler for the 5-stage pipeline; sits in ID beside load-use detection.
//  Merges load-use stall, EX branch/jump redirect, multi-cycle MUL/DIV occupancy and
//  data-memory wait into one per-stage write-enable/flush set.
//  Counts MUL/DIV latency, watches dmem wait with a timeout, and keeps a stall-cycle counter.
// PARAMETERS
//  MD_CYCLES    4     MUL/DIV latency in cycles incl. issue cycle (>=1; 1 = no stall)
//  MEM_TIMEOUT  255   max consecutive dmem wait cycles before mem_timeout_err (>=1)
//  CNT_W        32    width of stall_cycles counter
// PORTS
//  clk               in   1      clock, rising edge
//  rst               in   1      reset, synchronous, active-low
//  loaduse_stall_id  in   1      load-use hazard request from ID detection logic
//  branch_taken_ex   in   1      taken branch/jump resolved in EX
//  md_start_ex       in   1      MUL/DIV instr in EX; held high while it sits in EX
//  dmem_req_mem      in   1      MEM stage has an active dmem access
//  dmem_ready        in   1      dmem access completes this cycle
//  pc_we             out  1      PC write enable
//  ifid_we           out  1      IF/ID write enable
//  ifid_flush        out  1      IF/ID load bubble (NOP)
//  idex_we           out  1      ID/EX write enable
//  idex_flush        out  1      ID/EX load bubble (control fields = 0)
//  exmem_we          out  1      EX/MEM write enable
//  exmem_flush       out  1      EX/MEM load bubble
//  memwb_flush       out  1      MEM/WB load bubble
//  md_done           out  1      1-cycle pulse: MUL/DIV result valid, EX may advance
//  mem_timeout_err   out  1      sticky; dmem wait exceeded MEM_TIMEOUT
//  stall_cycles      out  CNT_W  count of cycles with pc_we==0
// BEHAVIOUR
//  Reset (rst==0 at a rising edge): state=RUN, md_cnt=0, wait_cnt=0, mem_timeout_err=0, stall_cycles=0.
//   While rst==0 all outputs are forced: *_we=0, all *_flush=1, md_done=0.
//  State reg: RUN, MD_BUSY. md_cnt is $clog2(MD_CYCLES) bits, min 1.
//  Condition mem_wait = dmem_req_mem & ~dmem_ready (combinational).
//  Condition md_stall = (RUN & md_start_ex & MD_CYCLES>1) | (MD_BUSY & md_cnt!=0).
//  Priority, highest first, evaluated every cycle:
//   1 mem_wait: pc/ifid/idex/exmem_we=0, memwb_flush=1, no other flush. md_cnt and state hold.
//   2 md_stall: pc/ifid/idex_we=0, exmem_flush=1.
//   3 branch_taken_ex: all we=1, ifid_flush=1, idex_flush=1; loaduse_stall_id ignored.
//   4 loaduse_stall_id: pc_we=0, ifid_we=0, idex_flush=1, exmem_we=1.
//   5 none: all we=1, all flush=0.
//  Flush and we for the same register are never both 1 (flush wins; we forced 0).
//  FSM, advances only when ~mem_wait:
//   RUN: md_start_ex & MD_CYCLES>1 -> MD_BUSY, md_cnt<=MD_CYCLES-2.
//   MD_BUSY: md_cnt!=0 -> md_cnt--. md_cnt==0 -> RUN, md_done=1, no stall this cycle.
//   md_start_ex is ignored in MD_BUSY. MD_CYCLES==1: never leaves RUN, md_done=1 whenever RUN&md_start_ex.
//  Total MUL/DIV stall = MD_CYCLES-1 cycles, plus any mem_wait cycles overlapping it.
//  Branch and MUL/DIV cannot both be in EX. branch_taken_ex under mem_wait is deferred, not lost:
//   it is held by EX and acted on at the first ~mem_wait cycle.
//  wait_cnt: mem_wait ? sat-increment : 0. When wait_cnt reaches MEM_TIMEOUT, set mem_timeout_err.
//   mem_timeout_err clears only on reset. Pipeline stays frozen; no forced recovery.
//  stall_cycles: +1 each cycle with rst==1 & pc_we==0; wraps modulo 2^CNT_W.
//  Outputs other than md_done, mem_timeout_err and stall_cycles are combinational from state + inputs.
//   Zero-cycle latency from request to control.
// STRUCTURE
//  riscv_def.v: state encodings (`HC_RUN, `HC_MD_BUSY), MD_CYCLES/MEM_TIMEOUT defaults.
//  One sub-module: hc_md_counter holds the MD_BUSY FSM and md_cnt, with a hold input = mem_wait.
//   The priority mux, watchdog and perf counter stay in the top.
// TESTING
//  T1 loaduse_stall_id=1 for 1 cycle, else idle -> pc_we=0, ifid_we=0, idex_flush=1 that cycle; stall_cycles=1.
//  T2 branch_taken_ex=1 and loaduse_stall_id=1 in the same cycle -> ifid_flush=1, idex_flush=1, pc_we=1; stall_cycles unchanged.
//  T3 MD_CYCLES=4, md_start_ex held -> pc_we=0 for cycles 0-2, exmem_flush=1 for cycles 0-2; md_done=1 and pc_we=1 in cycle 3.
//  T4 MD op with dmem_ready=0 for 2 cycles mid-op -> md_done delayed exactly 2 cycles; memwb_flush=1 for those 2 cycles.
//  T5 MEM_TIMEOUT=3, dmem_req_mem=1, dmem_ready=0 for 5 cycles -> mem_timeout_err=1 after 3rd wait cycle; stays 1 after dmem_ready.
//  T6 rst=0 asserted during MD_BUSY -> next cycle state RUN, counters 0, all flush=1 while rst=0; no md_done pulse.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_hazard_ctrl_pkg
// Description : Shared state encodings, parameter defaults, control-set type
//               and the cause-to-control table for the pipeline hazard
//               controller.
// Revision    : 1.0 - initial release
// ============================================================================
package pipeline_hazard_ctrl_pkg;

  // Parameter defaults for the hazard controller
  localparam int MD_CYCLES_DEF   = 4;
  localparam int MEM_TIMEOUT_DEF = 255;
  localparam int CNT_W_DEF       = 32;

  // MUL/DIV sequencer state encodings
  localparam logic [0:0] HC_RUN     = 1'b0;
  localparam logic [0:0] HC_MD_BUSY = 1'b1;

  // Winning hazard source for the current cycle, highest priority last
  typedef enum logic [2:0] {
    CAUSE_NONE    = 3'd0,
    CAUSE_LOADUSE = 3'd1,
    CAUSE_BRANCH  = 3'd2,
    CAUSE_MD      = 3'd3,
    CAUSE_MEM     = 3'd4,
    CAUSE_RESET   = 3'd5
  } hc_cause_e;

  // Per-stage write-enable / flush set driven to the pipeline registers
  typedef struct packed {
    logic pc_we;
    logic ifid_we;
    logic ifid_flush;
    logic idex_we;
    logic idex_flush;
    logic exmem_we;
    logic exmem_flush;
    logic memwb_flush;
  } hc_ctrl_t;

  // md_cnt width: enough to hold MD_CYCLES-2, never narrower than one bit
  function automatic int md_cnt_width(input int cycles);
    return (cycles <= 2) ? 1 : $clog2(cycles);
  endfunction

  // Translate the winning hazard cause into the stage control set
  function automatic hc_ctrl_t ctrl_for_cause(input hc_cause_e cause);
    hc_ctrl_t c;
    c = '0;
    case (cause)
      CAUSE_RESET: begin
        c.ifid_flush  = 1'b1;
        c.idex_flush  = 1'b1;
        c.exmem_flush = 1'b1;
        c.memwb_flush = 1'b1;
      end
      CAUSE_MEM: begin
        // Freeze everything up to EX/MEM; bubble into MEM/WB
        c.memwb_flush = 1'b1;
      end
      CAUSE_MD: begin
        // Hold front end, let older instructions drain behind a bubble
        c.exmem_flush = 1'b1;
      end
      CAUSE_BRANCH: begin
        c.pc_we      = 1'b1;
        c.ifid_flush = 1'b1;
        c.idex_flush = 1'b1;
        c.exmem_we   = 1'b1;
      end
      CAUSE_LOADUSE: begin
        c.idex_flush = 1'b1;
        c.exmem_we   = 1'b1;
      end
      default: begin
        c.pc_we    = 1'b1;
        c.ifid_we  = 1'b1;
        c.idex_we  = 1'b1;
        c.exmem_we = 1'b1;
      end
    endcase
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl_hc_md_counter.sv
`default_nettype none
// ============================================================================
// Module      : hc_md_counter
// Description : MUL/DIV occupancy sequencer. Tracks the RUN/MD_BUSY state and
//               the remaining latency of the operation sitting in EX, freezing
//               while hold (dmem wait) is asserted.
// Revision    : 1.0 - initial release
// ============================================================================
module hc_md_counter
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int MD_CYCLES = MD_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic hold,
  input  logic md_start_ex,
  output logic md_stall,
  output logic md_done
);

  localparam int                  MD_CNT_W = md_cnt_width(MD_CYCLES);
  localparam logic                MD_MULTI = (MD_CYCLES > 1);
  localparam logic [MD_CNT_W-1:0] MD_LOAD  = (MD_CYCLES > 1) ? MD_CNT_W'(MD_CYCLES - 2) : '0;

  logic [0:0]          state_q;
  logic [0:0]          state_d;
  logic [MD_CNT_W-1:0] md_cnt_q;
  logic [MD_CNT_W-1:0] md_cnt_d;

  // Next-state, stall request and completion pulse for the op in EX
  always_comb begin
    state_d  = state_q;
    md_cnt_d = md_cnt_q;
    md_stall = 1'b0;
    md_done  = 1'b0;
    case (state_q)
      HC_RUN: begin
        if (md_start_ex) begin
          if (MD_MULTI) begin
            // Issue cycle already counts toward latency
            md_stall = 1'b1;
            if (!hold) begin
              state_d  = HC_MD_BUSY;
              md_cnt_d = MD_LOAD;
            end
          end else if (!hold) begin
            md_done = 1'b1;
          end
        end
      end
      HC_MD_BUSY: begin
        if (md_cnt_q != '0) begin
          md_stall = 1'b1;
          if (!hold) begin
            md_cnt_d = md_cnt_q - MD_CNT_W'(1);
          end
        end else if (!hold) begin
          // Result ready; EX may advance this cycle
          md_done = 1'b1;
          state_d = HC_RUN;
        end
      end
      default: begin
        state_d  = HC_RUN;
        md_cnt_d = '0;
      end
    endcase
  end

  // State and latency counter registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= HC_RUN;
      md_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      md_cnt_q <= md_cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_hazard_ctrl
// Description : Central stall/flush scheduler for the 5-stage pipeline.
//               Merges dmem wait, MUL/DIV occupancy, EX redirect and load-use
//               hazards into one per-stage write-enable/flush set, watches
//               dmem wait with a timeout and counts stalled cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int MD_CYCLES   = MD_CYCLES_DEF,
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             loaduse_stall_id,
  input  logic             branch_taken_ex,
  input  logic             md_start_ex,
  input  logic             dmem_req_mem,
  input  logic             dmem_ready,
  output logic             pc_we,
  output logic             ifid_we,
  output logic             ifid_flush,
  output logic             idex_we,
  output logic             idex_flush,
  output logic             exmem_we,
  output logic             exmem_flush,
  output logic             memwb_flush,
  output logic             md_done,
  output logic             mem_timeout_err,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int                WAIT_W   = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

  logic              w_mem_wait;
  logic              w_md_stall;
  logic              w_md_done;
  hc_cause_e         w_cause;
  hc_ctrl_t          w_ctrl;

  logic [WAIT_W-1:0] wait_cnt_q;
  logic [WAIT_W-1:0] wait_cnt_d;
  logic              mem_timeout_err_q;
  logic              mem_timeout_err_d;
  logic [CNT_W-1:0]  stall_cycles_q;
  logic [CNT_W-1:0]  stall_cycles_d;

  assign w_mem_wait = dmem_req_mem & ~dmem_ready;

  hc_md_counter #(
    .MD_CYCLES (MD_CYCLES)
  ) u_md_counter (
    .clk         (clk),
    .rst         (rst),
    .hold        (w_mem_wait),
    .md_start_ex (md_start_ex),
    .md_stall    (w_md_stall),
    .md_done     (w_md_done)
  );

  // Pick the single highest-priority hazard for this cycle
  always_comb begin
    w_cause = CAUSE_NONE;
    if (!rst) begin
      w_cause = CAUSE_RESET;
    end else if (w_mem_wait) begin
      w_cause = CAUSE_MEM;
    end else if (w_md_stall) begin
      w_cause = CAUSE_MD;
    end else if (branch_taken_ex) begin
      // A redirect squashes the instruction that raised load-use
      w_cause = CAUSE_BRANCH;
    end else if (loaduse_stall_id) begin
      w_cause = CAUSE_LOADUSE;
    end
  end

  // Drive stage controls; a bubble load always overrides a write enable
  always_comb begin
    w_ctrl       = ctrl_for_cause(w_cause);
    pc_we        = w_ctrl.pc_we;
    ifid_we      = w_ctrl.ifid_we & ~w_ctrl.ifid_flush;
    ifid_flush   = w_ctrl.ifid_flush;
    idex_we      = w_ctrl.idex_we & ~w_ctrl.idex_flush;
    idex_flush   = w_ctrl.idex_flush;
    exmem_we     = w_ctrl.exmem_we & ~w_ctrl.exmem_flush;
    exmem_flush  = w_ctrl.exmem_flush;
    memwb_flush  = w_ctrl.memwb_flush;
    md_done      = rst & w_md_done;
  end

  // Dmem watchdog and stall-cycle counter next values
  always_comb begin
    wait_cnt_d = '0;
    if (w_mem_wait) begin
      wait_cnt_d = (wait_cnt_q == WAIT_MAX) ? WAIT_MAX : wait_cnt_q + WAIT_W'(1);
    end
    // Flag in the same cycle the counter lands on the limit
    mem_timeout_err_d = mem_timeout_err_q | (wait_cnt_d == WAIT_MAX);
    stall_cycles_d    = stall_cycles_q + CNT_W'(!pc_we);
  end

  // Watchdog, sticky error and performance counter registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      wait_cnt_q        <= '0;
      mem_timeout_err_q <= 1'b0;
      stall_cycles_q    <= '0;
    end else begin
      wait_cnt_q        <= wait_cnt_d;
      mem_timeout_err_q <= mem_timeout_err_d;
      stall_cycles_q    <= stall_cycles_d;
    end
  end

  assign mem_timeout_err = mem_timeout_err_q;
  assign stall_cycles    = stall_cycles_q;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_hazard_ctrl
// Description : Self-checking bench for pipeline_hazard_ctrl: directed hazard
//               scenarios followed by constrained-random traffic, compared
//               against a cycle-level behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_hazard_ctrl;

  localparam int MD_CYCLES   = 4;
  localparam int MEM_TIMEOUT = 3;
  localparam int CNT_W       = 32;

  logic             clk;
  logic             rst;
  logic             loaduse_stall_id;
  logic             branch_taken_ex;
  logic             md_start_ex;
  logic             dmem_req_mem;
  logic             dmem_ready;
  logic             pc_we;
  logic             ifid_we;
  logic             ifid_flush;
  logic             idex_we;
  logic             idex_flush;
  logic             exmem_we;
  logic             exmem_flush;
  logic             memwb_flush;
  logic             md_done;
  logic             mem_timeout_err;
  logic [CNT_W-1:0] stall_cycles;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state
  logic        m_md_active;
  int          m_md_elapsed;
  logic        m_md_hold;
  int          m_wait_run;
  logic        m_err;
  logic [31:0] m_stall;

  pipeline_hazard_ctrl #(
    .MD_CYCLES   (MD_CYCLES),
    .MEM_TIMEOUT (MEM_TIMEOUT),
    .CNT_W       (CNT_W)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .loaduse_stall_id (loaduse_stall_id),
    .branch_taken_ex  (branch_taken_ex),
    .md_start_ex      (md_start_ex),
    .dmem_req_mem     (dmem_req_mem),
    .dmem_ready       (dmem_ready),
    .pc_we            (pc_we),
    .ifid_we          (ifid_we),
    .ifid_flush       (ifid_flush),
    .idex_we          (idex_we),
    .idex_flush       (idex_flush),
    .exmem_we         (exmem_we),
    .exmem_flush      (exmem_flush),
    .memwb_flush      (memwb_flush),
    .md_done          (md_done),
    .mem_timeout_err  (mem_timeout_err),
    .stall_cycles     (stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected {pc_we, ifid_we, ifid_flush, idex_we, idex_flush, exmem_we, exmem_flush, memwb_flush}
  function automatic logic [7:0] expect_ctrl(input logic r, input logic mw, input logic mds,
                                             input logic br, input logic lu);
    if (!r)       return 8'b0010_1011;
    else if (mw)  return 8'b0000_0001;
    else if (mds) return 8'b0000_0010;
    else if (br)  return 8'b1010_1100;
    else if (lu)  return 8'b0000_1100;
    else          return 8'b1101_0100;
  endfunction

  task automatic model_reset();
    m_md_active  = 1'b0;
    m_md_elapsed = 0;
    m_md_hold    = 1'b0;
    m_wait_run   = 0;
    m_err        = 1'b0;
    m_stall      = '0;
  endtask

  // Apply one cycle of inputs at negedge, check combinational outputs,
  // advance the model at posedge, then check registered outputs
  task automatic do_cycle(input logic r, input logic lu, input logic br,
                          input logic md, input logic rq, input logic rd);
    logic       mw;
    logic       in_op;
    int         el;
    logic       mds;
    logic       exp_done;
    logic [7:0] exp_ctrl;
    rst              = r;
    loaduse_stall_id = lu;
    branch_taken_ex  = br;
    md_start_ex      = md;
    dmem_req_mem     = rq;
    dmem_ready       = rd;
    mw       = rq & ~rd;
    in_op    = m_md_active | md;
    el       = m_md_active ? m_md_elapsed : 0;
    mds      = in_op && (el < MD_CYCLES - 1);
    exp_done = r && in_op && (el == MD_CYCLES - 1) && !mw;
    exp_ctrl = expect_ctrl(r, mw, mds, br, lu);
    #1;
    check("ctrl", {24'd0, pc_we, ifid_we, ifid_flush, idex_we, idex_flush,
                   exmem_we, exmem_flush, memwb_flush}, {24'd0, exp_ctrl});
    check("md_done", {31'd0, md_done}, {31'd0, exp_done});
    @(posedge clk);
    if (!r) begin
      model_reset();
    end else begin
      if (!exp_ctrl[7]) m_stall = m_stall + 32'd1;
      if (mw) begin
        m_wait_run++;
        if (m_wait_run >= MEM_TIMEOUT) m_err = 1'b1;
      end else begin
        m_wait_run = 0;
      end
      if (!mw && in_op) begin
        if (exp_done) begin
          m_md_active  = 1'b0;
          m_md_elapsed = 0;
        end else begin
          m_md_active  = 1'b1;
          m_md_elapsed = el + 1;
        end
      end
      m_md_hold = in_op && !exp_done;
    end
    #1;
    check("stall_cycles", stall_cycles, m_stall);
    check("mem_timeout_err", {31'd0, mem_timeout_err}, {31'd0, m_err});
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] stall_before;
    logic        r_lu, r_br, r_md, r_rq, r_rd, r_rst;
    rst              = 1'b0;
    loaduse_stall_id = 1'b0;
    branch_taken_ex  = 1'b0;
    md_start_ex      = 1'b0;
    dmem_req_mem     = 1'b0;
    dmem_ready       = 1'b0;
    model_reset();
    @(negedge clk);

    // Reset state, then idle
    do_cycle(0, 0, 0, 0, 0, 0);
    do_cycle(0, 1, 1, 1, 1, 0);
    do_cycle(1, 0, 0, 0, 0, 0);

    // T1: single load-use stall
    stall_before = stall_cycles;
    do_cycle(1, 1, 0, 0, 0, 0);
    do_cycle(1, 0, 0, 0, 0, 0);
    check("t1_stall_delta", stall_cycles - stall_before, 32'd1);

    // T2: branch overrides load-use
    stall_before = stall_cycles;
    do_cycle(1, 1, 1, 0, 0, 0);
    check("t2_stall_delta", stall_cycles - stall_before, 32'd0);

    // T3: MUL/DIV held in EX for full latency
    for (int i = 0; i < MD_CYCLES; i++) do_cycle(1, 0, 0, 1, 0, 0);
    do_cycle(1, 0, 0, 0, 0, 0);

    // T4: two dmem wait cycles in the middle of a MUL/DIV op
    for (int i = 0; i < MD_CYCLES + 2; i++) begin
      do_cycle(1, 0, 0, 1, (i == 1 || i == 2), 1'b0);
    end
    do_cycle(1, 0, 0, 0, 1, 1);

    // T5: dmem wait long enough to trip the watchdog, then complete
    for (int i = 0; i < 5; i++) do_cycle(1, 0, 0, 0, 1, 0);
    do_cycle(1, 0, 0, 0, 1, 1);
    do_cycle(1, 0, 0, 0, 0, 0);
    check("t5_err_sticky", {31'd0, mem_timeout_err}, 32'd1);

    // T6: reset while MUL/DIV is busy
    do_cycle(1, 0, 0, 1, 0, 0);
    do_cycle(1, 0, 0, 1, 0, 0);
    do_cycle(0, 0, 0, 1, 0, 0);
    do_cycle(0, 0, 0, 1, 0, 0);
    do_cycle(1, 0, 0, 0, 0, 0);
    check("t6_err_cleared", {31'd0, mem_timeout_err}, 32'd0);

    // Constrained-random traffic
    for (int i = 0; i < 600; i++) begin
      r_rst = ($urandom_range(0, 59) != 0);
      r_md  = m_md_hold ? 1'b1 : ($urandom_range(0, 5) == 0);
      r_br  = r_md ? 1'b0 : ($urandom_range(0, 4) == 0);
      r_lu  = ($urandom_range(0, 3) == 0);
      r_rq  = $urandom_range(0, 1);
      r_rd  = ($urandom_range(0, 2) != 0);
      do_cycle(r_rst, r_lu, r_br, r_md, r_rq, r_rd);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
